// File: rtl/instr_mem_banked_pkg.sv
// Shared types and constants for the banked instruction memory.
// NOOP_WORD is what fetch presents before the first accepted fetch.
package instr_mem_banked_pkg;

    localparam int unsigned INSTR_W = 9;

    localparam logic [2:0] FUNC_SYS = 3'b111;
    localparam logic [5:0] OP_NOOP  = 6'b000000;

    localparam logic [INSTR_W-1:0] NOOP_WORD = {FUNC_SYS, OP_NOOP};

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    // Bank-select width; a single bank still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_banked_if.sv
// Fetch and loader signals between host/fetch stage (master) and the memory (slave).
interface instr_mem_banked_if #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 10,
    parameter int unsigned BW = 2
);
    logic          fetch_req;
    logic [BW-1:0] fetch_bank;
    logic [AW-1:0] pc;
    logic          fetch_rdy;
    logic [IW-1:0] instr;
    logic          instr_vld;

    logic          ld_start;
    logic [BW-1:0] ld_bank;
    logic [AW-1:0] ld_base;
    logic [IW-1:0] ld_data;
    logic          ld_vld;
    logic          ld_last;
    logic          ld_rdy;
    logic          ld_busy;
    logic          ld_done;
    logic          ld_err;

    modport master (
        output fetch_req, fetch_bank, pc,
        input  fetch_rdy, instr, instr_vld,
        output ld_start, ld_bank, ld_base, ld_data, ld_vld, ld_last,
        input  ld_rdy, ld_busy, ld_done, ld_err
    );

    modport slave (
        input  fetch_req, fetch_bank, pc,
        output fetch_rdy, instr, instr_vld,
        input  ld_start, ld_bank, ld_base, ld_data, ld_vld, ld_last,
        output ld_rdy, ld_busy, ld_done, ld_err
    );

endinterface

// File: rtl/imem_bank.sv
// One program bank: synchronous write, registered read. Array contents are never reset;
// only the read register is, so instr starts at a known word.
module imem_bank #(
    parameter int unsigned   IW      = 9,
    parameter int unsigned   AW      = 10,
    parameter logic [IW-1:0] RstWord = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem_q [2**AW];
    logic [IW-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= RstWord;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Banked instruction memory: 1-cycle fetch from any bank plus a run-time loader that streams
// a program into one bank; fetches to the bank being loaded are stalled.
module instr_mem_banked
    import instr_mem_banked_pkg::*;
#(
    parameter int unsigned IW    = 9,
    parameter int unsigned AW    = 10,
    parameter int unsigned NBANK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_mem_banked_if.slave  bus
);

    localparam int unsigned   BW      = sel_width(NBANK);
    localparam logic [IW-1:0] RstWord = IW'(NOOP_WORD);

    ld_state_e     state_d, state_q;
    logic [BW-1:0] bank_d, bank_q;
    logic [AW-1:0] ptr_d, ptr_q;
    logic          err_d, err_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic [BW-1:0] fsel_d, fsel_q;
    logic          vld_d, vld_q;

    logic          we;
    logic          fetch_rdy;
    logic          fetch_acc;
    logic [IW-1:0] rdata [NBANK];

    // Only the bank under load is blocked; this also rules out same-bank read/write collisions.
    assign fetch_rdy = !(busy_q && (bus.fetch_bank == bank_q));
    assign fetch_acc = bus.fetch_req && fetch_rdy;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we      = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (bus.ld_start) begin
                    state_d = LD_WRITE;
                    bank_d  = bus.ld_bank;
                    ptr_d   = bus.ld_base;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LD_WRITE: begin
                if (bus.ld_vld) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (bus.ld_last) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                    end else if (ptr_q == '1) begin
                        // Session ran off the top of the bank: keep the word, flag and close.
                        state_d = LD_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_comb begin
        vld_d  = fetch_acc;
        fsel_d = fetch_acc ? bus.fetch_bank : fsel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            bank_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fsel_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fsel_q  <= fsel_d;
            vld_q   <= vld_d;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        imem_bank #(
            .IW      (IW),
            .AW      (AW),
            .RstWord (RstWord)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we && (bank_q == BW'(b))),
            .waddr (ptr_q),
            .wdata (bus.ld_data),
            .re    (fetch_acc && (bus.fetch_bank == BW'(b))),
            .raddr (bus.pc),
            .rdata (rdata[b])
        );
    end

    assign bus.fetch_rdy = fetch_rdy;
    assign bus.instr     = rdata[fsel_q];
    assign bus.instr_vld = vld_q;
    assign bus.ld_rdy    = (state_q == LD_WRITE);
    assign bus.ld_busy   = busy_q;
    assign bus.ld_done   = done_q;
    assign bus.ld_err    = err_q;

endmodule
